// File: rtl/fifo_flujo.sv
// fifo_flujo: synchronous FIFO with programmable almost-full/almost-empty
// thresholds, registered status flags and sticky overflow/underflow errors.
// Storage is not reset; pointers, count, flags and read data are.
module fifo_flujo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   umbral_af,
  input  logic [ADDR_WIDTH:0]   umbral_ae,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  error_overflow,
  output logic                  error_underflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage array (intentionally without reset)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // State registers and their next-state values
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  empty_q, empty_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_unf_q, err_unf_d;

  // Accepted operations; a read on a full FIFO frees room for a same-cycle write
  logic rd_ok, wr_ok;

  // Acceptance of read/write requests from the registered flags
  always_comb begin
    rd_ok = rd_en && !empty_q;
    wr_ok = wr_en && (!full_q || rd_ok);
  end

  // Next-state for pointers, occupancy, read data, flags and sticky errors
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_unf_d   = err_unf_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_ok) begin
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end else begin
      rd_ptr_d    = rd_ptr_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    if (wr_en && !wr_ok) begin
      err_ovf_d = 1'b1;
    end else begin
      err_ovf_d = err_ovf_q;
    end

    if (rd_en && !rd_ok) begin
      err_unf_d = 1'b1;
    end else begin
      err_unf_d = err_unf_q;
    end

    // Flags follow the occupancy after this edge and the thresholds sampled now
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == {(ADDR_WIDTH + 1){1'b0}});
    almost_full_d  = (count_d >= umbral_af);
    almost_empty_d = (count_d <= umbral_ae);
  end

  // Control/status state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q       <= {ADDR_WIDTH{1'b0}};
      count_q        <= {(ADDR_WIDTH + 1){1'b0}};
      data_out_q     <= {DATA_WIDTH{1'b0}};
      valid_out_q    <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      err_ovf_q      <= 1'b0;
      err_unf_q      <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      valid_out_q    <= valid_out_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      err_ovf_q      <= err_ovf_d;
      err_unf_q      <= err_unf_d;
    end
  end

  // Memory write port; reset blocks the write so no word is stored
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out        = data_out_q;
  assign valid_out       = valid_out_q;
  assign count           = count_q;
  assign full            = full_q;
  assign almost_full     = almost_full_q;
  assign empty           = empty_q;
  assign almost_empty    = almost_empty_q;
  assign error_overflow  = err_ovf_q;
  assign error_underflow = err_unf_q;

endmodule
